mc_client_dump_sequencer: RTL and testbench

//   Automatic post-run dump controller for MiniComputer's client debug ports.
//   On Go it waits for CPUReady, then sweeps instruction memory through

---
 rtl/mc_dump_pkg.sv | 9 +
 rtl/mc_dump_addr_gen.sv | 22 ++
 rtl/mc_client_dump_sequencer.sv | 122 ++++++++++++
 tb/tb_mc_client_dump_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mc_dump_pkg.sv
// mc_dump_pkg: sequencer states, client read codes and stream space encodings
package mc_dump_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_CPU, S_ISSUE, S_CAPT, S_PRESENT, S_DONE} state_e;
  localparam logic [1:0] CRIM_RD = 2'h3;
  localparam logic [1:0] CRDM_RD = 2'h1;
  localparam logic [1:0] CR_IDLE = 2'h0;
  localparam logic SPACE_INS = 1'b0;
  localparam logic SPACE_MEM = 1'b1;
endpackage

// File: rtl/mc_dump_addr_gen.sv
// mc_dump_addr_gen: base + idx*stride word address with a last-word flag
module mc_dump_addr_gen #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE = '0,
  parameter int STRIDE = 1,
  parameter int WORDS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [31:0] idx_q, idx_d;
  always_comb idx_d = clr ? '0 : adv ? idx_q + 32'd1 : idx_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) idx_q <= '0;
    else idx_q <= idx_d;
  assign addr = BASE + ADDR_W'(idx_q) * ADDR_W'(STRIDE);
  assign last = idx_q == 32'(WORDS - 1);
endmodule

// File: rtl/mc_client_dump_sequencer.sv
// mc_client_dump_sequencer: sweeps instruction then data memory onto a valid/ready dump stream.
// MC_DUMP_CHECKSUM_EN adds DumpSum, the running sum of accepted DumpData.
module mc_client_dump_sequencer
  import mc_dump_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] INS_BASE = 32'h0,
  parameter int INS_WORDS = 25,
  parameter int INS_STRIDE = 4,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000,
  parameter int MEM_WORDS = 32,
  parameter int MEM_STRIDE = 1,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Go,
  input  logic              Abort,
  input  logic              CPUReady,
  output logic [ADDR_W-1:0] ClientInsAddr,
  output logic [1:0]        CRIM,
  input  logic [DATA_W-1:0] ClientInsRead,
  output logic [ADDR_W-1:0] ClientMemAddr,
  output logic [1:0]        CRDM,
  input  logic [DATA_W-1:0] ClientMemRead,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [DATA_W-1:0] DumpData,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic              DumpSpace,
  output logic              DumpLast,
  output logic              Busy,
  output logic              Done
`ifdef MC_DUMP_CHECKSUM_EN
  , output logic [DATA_W-1:0] DumpSum
`endif
);
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  localparam bit HAS_INS = INS_WORDS > 0;
  localparam bit HAS_MEM = MEM_WORDS > 0;
  state_e state_q, state_d;
  logic space_q, space_d, last_q, last_d;
  logic [2:0] lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ins_addr, mem_addr;
  logic ins_last, mem_last, hs, go_ok, clr, rd, capt;
  assign go_ok = Go && !Abort && (state_q == S_IDLE || state_q == S_DONE);
  assign hs = state_q == S_PRESENT && DumpReady;
  assign clr = go_ok || Abort;
  assign rd = state_q == S_ISSUE || state_q == S_CAPT;
  assign capt = (state_q == S_ISSUE && RD_LAT == 1) || (state_q == S_CAPT && lat_q == 3'd0);
  mc_dump_addr_gen #(.ADDR_W(ADDR_W), .BASE(INS_BASE), .STRIDE(INS_STRIDE), .WORDS(INS_WORDS)) u_ins (
    .clk(Clk), .rst(Rst), .clr(clr), .adv(hs && space_q == SPACE_INS), .addr(ins_addr), .last(ins_last));
  mc_dump_addr_gen #(.ADDR_W(ADDR_W), .BASE(MEM_BASE), .STRIDE(MEM_STRIDE), .WORDS(MEM_WORDS)) u_mem (
    .clk(Clk), .rst(Rst), .clr(clr), .adv(hs && space_q == SPACE_MEM), .addr(mem_addr), .last(mem_last));
  always_comb begin
    state_d = state_q;
    space_d = space_q;
    lat_d = lat_q;
    data_d = data_q;
    addr_d = addr_q;
    last_d = last_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = go_ok ? S_WAIT_CPU : state_q;
      S_WAIT_CPU: if (CPUReady) begin
        state_d = (HAS_INS || HAS_MEM) ? S_ISSUE : S_DONE;
        space_d = HAS_INS ? SPACE_INS : SPACE_MEM;
      end
      S_ISSUE, S_CAPT: begin
        lat_d = state_q == S_ISSUE ? LAT_LOAD : lat_q - 3'd1;
        state_d = capt ? S_PRESENT : S_CAPT;
        if (capt) begin
          data_d = space_q ? ClientMemRead : ClientInsRead;
          addr_d = space_q ? mem_addr : ins_addr;
          last_d = space_q ? mem_last : ins_last && !HAS_MEM;
        end
      end
      S_PRESENT: if (DumpReady) begin
        state_d = last_q ? S_DONE : S_ISSUE;
        space_d = space_q || ins_last;
      end
      default: state_d = S_IDLE;
    endcase
    if (Abort) state_d = S_IDLE;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state_q <= S_IDLE;
      space_q <= SPACE_INS;
      last_q <= 1'b0;
      lat_q <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      space_q <= space_d;
      last_q <= last_d;
      lat_q <= lat_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  assign CRIM = rd && space_q == SPACE_INS ? CRIM_RD : CR_IDLE;
  assign CRDM = rd && space_q == SPACE_MEM ? CRDM_RD : CR_IDLE;
  assign ClientInsAddr = CRIM != CR_IDLE ? ins_addr : '0;
  assign ClientMemAddr = CRDM != CR_IDLE ? mem_addr : '0;
  assign DumpValid = state_q == S_PRESENT;
  assign DumpData = data_q;
  assign DumpAddr = addr_q;
  assign DumpSpace = space_q;
  assign DumpLast = DumpValid && last_q;
  assign Busy = state_q inside {S_WAIT_CPU, S_ISSUE, S_CAPT, S_PRESENT};
  assign Done = state_q == S_DONE;
`ifdef MC_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  always_comb sum_d = go_ok ? '0 : hs ? sum_q + data_q : sum_q;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) sum_q <= '0;
    else sum_q <= sum_d;
  assign DumpSum = sum_q;
`endif
endmodule

// File: tb/tb_mc_client_dump_sequencer.sv
// tb_mc_client_dump_sequencer: table-driven dump runs with a beat scoreboard plus corner sequences
module tb_mc_client_dump_sequencer;
  logic clk = 0, rst = 1, go = 0, abort = 0, cpu_rdy = 0, dr = 0;
  logic [31:0] ins_addr, ins_rd, mem_addr, mem_rd, dd, da;
  logic [1:0] crim, crdm;
  logic dv, ds, dl, busy, done;
  logic go1 = 0, ab1 = 0, dr1 = 1;
  logic [31:0] ins_addr1, ins_rd1, mem_addr1, mem_rd1, dd1, da1;
  logic [1:0] crim1, crdm1;
  logic dv1, ds1, dl1, busy1, done1;
`ifdef MC_DUMP_CHECKSUM_EN
  logic [31:0] dsum, dsum1;
`endif
  always #5 clk = ~clk;
  mc_client_dump_sequencer u0 (
    .Clk(clk), .Rst(rst), .Go(go), .Abort(abort), .CPUReady(cpu_rdy),
    .ClientInsAddr(ins_addr), .CRIM(crim), .ClientInsRead(ins_rd),
    .ClientMemAddr(mem_addr), .CRDM(crdm), .ClientMemRead(mem_rd),
    .DumpValid(dv), .DumpReady(dr), .DumpData(dd), .DumpAddr(da),
    .DumpSpace(ds), .DumpLast(dl), .Busy(busy), .Done(done)
`ifdef MC_DUMP_CHECKSUM_EN
    , .DumpSum(dsum)
`endif
  );
  mc_client_dump_sequencer #(.INS_WORDS(0), .MEM_WORDS(1), .RD_LAT(3)) u1 (
    .Clk(clk), .Rst(rst), .Go(go1), .Abort(ab1), .CPUReady(cpu_rdy),
    .ClientInsAddr(ins_addr1), .CRIM(crim1), .ClientInsRead(ins_rd1),
    .ClientMemAddr(mem_addr1), .CRDM(crdm1), .ClientMemRead(mem_rd1),
    .DumpValid(dv1), .DumpReady(dr1), .DumpData(dd1), .DumpAddr(da1),
    .DumpSpace(ds1), .DumpLast(dl1), .Busy(busy1), .Done(done1)
`ifdef MC_DUMP_CHECKSUM_EN
    , .DumpSum(dsum1)
`endif
  );
  // memories answer only in the read-latency cycle, otherwise return junk
  int icnt, mcnt, mcnt1;
  always @(posedge clk or posedge rst)
    if (rst) begin
      icnt <= 0;
      mcnt <= 0;
      mcnt1 <= 0;
    end else begin
      icnt <= crim != 0 ? icnt + 1 : 0;
      mcnt <= crdm != 0 ? mcnt + 1 : 0;
      mcnt1 <= crdm1 != 0 ? mcnt1 + 1 : 0;
    end
  assign ins_rd = (crim == 2'h3 && icnt == 0) ? (ins_addr >> 2) + 32'd1 : 32'hDEADBEEF;
  assign mem_rd = (crdm == 2'h1 && mcnt == 0) ? mem_addr - 32'h8000 + 32'd26 : 32'hDEADBEEF;
  assign ins_rd1 = 32'hDEADBEEF;
  assign mem_rd1 = (crdm1 == 2'h1 && mcnt1 == 2) ? mem_addr1 - 32'h8000 + 32'd26 : 32'hDEADBEEF;

  typedef struct {logic [31:0] a; logic s; logic [31:0] d; logic l;} beat_t;
  typedef struct {int cpu_delay; int rdy_pct; int abort_beat; int exp_beats; bit exp_done;} vec_t;
  beat_t q[$];
  vec_t v[5];
  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    beat_t b, e;
    int n = 0, cyc = 0;
    bit aborted = 0, stalled = 0, quiet = 1, r;
    q.delete();
    for (int i = 0; i < 25; i++) q.push_back('{32'(i * 4), 1'b0, 32'(i + 1), 1'b0});
    for (int j = 0; j < 32; j++) q.push_back('{32'h8000 + 32'(j), 1'b1, 32'(j + 26), j == 31});
    @(negedge clk);
    go = 1;
    dr = 0;
    cpu_rdy = t.cpu_delay == 0;
    @(negedge clk);
    go = 0;
    chk("busy_after_go", 64'(busy), 64'd1);
    if (t.cpu_delay > 0) begin
      repeat (t.cpu_delay) begin
        @(negedge clk);
        if (crim != 0 || crdm != 0) quiet = 0;
      end
      chk("quiet_while_cpu_busy", 64'(quiet), 64'd1);
      cpu_rdy = 1;
      @(negedge clk);
      chk("sweep_start_crim", 64'(crim), 64'd3);
      chk("sweep_start_addr", 64'(ins_addr), 64'd0);
    end
    while (n < 57 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (crim != 0 && crdm != 0) chk("cr_exclusive", {crim, crdm}, 64'd0);
      if (stalled) begin
        chk("stall_valid", 64'(dv), 64'd1);
        chk("stall_ctl", {ds, dl, da}, {b.s, b.l, b.a});
        chk("stall_data", 64'(dd), 64'(b.d));
      end
      if (dv && n == t.abort_beat) begin
        abort = 1;
        dr = 0;
        @(negedge clk);
        abort = 0;
        chk("abort_cr", {crim, crdm}, 64'd0);
        aborted = 1;
        break;
      end
      r = $urandom_range(99) < t.rdy_pct;
      dr = r;
      if (dv && r) begin
        e = q.pop_front();
        chk("beat_ctl", {ds, dl, da}, {e.s, e.l, e.a});
        chk("beat_data", 64'(dd), 64'(e.d));
        n++;
      end
      stalled = dv && !r;
      b = '{da, ds, dd, dl};
    end
    if (cyc >= 5000) chk("beat_timeout", 64'(n), 64'(t.exp_beats));
    if (!aborted) @(negedge clk);
    dr = 0;
    chk("beat_count", 64'(n), 64'(t.exp_beats));
    chk("done_level", 64'(done), 64'(t.exp_done));
    chk("busy_end", 64'(busy), 64'd0);
    chk("valid_end", 64'(dv), 64'd0);
`ifdef MC_DUMP_CHECKSUM_EN
    if (t.exp_done) chk("dump_sum", 64'(dsum), 64'd1653);
`endif
  endtask

  initial begin
    int crdm_cyc = 0, crim_cyc = 0, got = 0;
    v[0] = '{0, 100, -1, 57, 1'b1};
    v[1] = '{0, 50, -1, 57, 1'b1};
    v[2] = '{500, 100, -1, 57, 1'b1};
    v[3] = '{0, 60, 35, 35, 1'b0};
    v[4] = '{0, 100, -1, 57, 1'b1};
    #22;
    chk("rst_cr", {crim, crdm}, 64'd0);
    chk("rst_addrs", {ins_addr, mem_addr}, 64'd0);
    chk("rst_stream", {dv, ds, dl, da}, 64'd0);
    chk("rst_data", 64'(dd), 64'd0);
    chk("rst_status", {busy, done, busy1, done1}, 64'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) run(v[i]);
    @(negedge clk);
    go = 1;
    abort = 1;
    @(negedge clk);
    go = 0;
    abort = 0;
    chk("abort_beats_go", {busy, done}, 64'd0);
    cpu_rdy = 1;
    go1 = 1;
    @(negedge clk);
    go1 = 0;
    for (int c = 0; c < 50 && !done1; c++) begin
      @(negedge clk);
      if (crim1 != 0) crim_cyc++;
      if (crdm1 == 2'h1) begin
        if (crdm_cyc == 0) chk("single_addr", 64'(mem_addr1), 64'h8000);
        crdm_cyc++;
      end
      if (dv1) begin
        got++;
        chk("single_ctl", {ds1, dl1, da1}, {2'b11, 32'h8000});
        chk("single_data", 64'(dd1), 64'd26);
      end
    end
    chk("single_crdm_cycles", 64'(crdm_cyc), 64'd3);
    chk("single_crim_idle", 64'(crim_cyc), 64'd0);
    chk("single_beats", 64'(got), 64'd1);
    chk("single_done", {done1, busy1}, 64'b10);
    @(negedge clk);
    go = 1;
    @(negedge clk);
    go = 0;
    repeat (7) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_status", {busy, done, dv, dl}, 64'd0);
    chk("async_rst_cr", {crim, crdm, ins_addr}, 64'd0);
    @(negedge clk);
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
